// File: rtl/sel_mux_rr.sv
// rtl/sel_mux_rr.sv - registered N-channel selector, fixed-select or round-robin, valid/ready on all ports
module sel_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;
    logic             space;
    logic             load;

    // Channel reached after stepping off positions past base, wrapping at CHANNELS.
    function automatic int rr_index(input int base, input int off);
        int s;
        s = base + off;
        return (s >= CHANNELS) ? s - CHANNELS : s;
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end else begin
            // Walk from the farthest offset down so the nearest requester after ptr wins.
            for (int i = CHANNELS; i >= 1; i--) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (rr_index(int'(ptr_q), i) == k && in_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign space = !out_valid_q || out_ready;
    assign load  = space && grant_vld && !rst;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ready[k] = load && (grant_idx == SEL_W'(k));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sel_mux_rr.sv
// tb/tb_sel_mux_rr.sv - self-checking bench for sel_mux_rr with a queue-free behavioural model
module tb_sel_mux_rr;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;

    int n_vec = 0;
    int n_err = 0;

    int         m_ptr   = 3;
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_chan  = 0;

    logic [3:0] act_rdy;
    logic [3:0] exp_rdy;
    logic [2:0] act_rdy3;

    sel_mux_rr #(.WIDTH(8), .CHANNELS(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    sel_mux_rr #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
        .out_valid(out_valid3), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant();
        if (!mode) begin
            return in_valid[sel] ? int'(sel) : -1;
        end
        for (int i = 1; i <= 4; i++) begin
            if (in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    // Samples in_ready mid-cycle, computes the model's next state, then advances one edge.
    task automatic step();
        int         g;
        bit         space;
        int         n_ptr;
        bit         n_valid;
        logic [7:0] n_data;
        int         n_chan;
        @(negedge clk);
        act_rdy  = in_ready;
        act_rdy3 = in_ready3;
        g        = model_grant();
        space    = !m_valid || out_ready;
        exp_rdy  = (!rst && space && g >= 0) ? (4'b0001 << g) : 4'b0000;
        n_ptr = m_ptr; n_valid = m_valid; n_data = m_data; n_chan = m_chan;
        if (rst) begin
            n_ptr = 3; n_valid = 1'b0; n_data = 8'h00; n_chan = 0;
        end else if (space && g >= 0) begin
            n_data  = in_data[g*8 +: 8];
            n_chan  = g;
            n_valid = 1'b1;
            if (mode) n_ptr = g;
        end else if (m_valid && out_ready) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_ptr = n_ptr; m_valid = n_valid; m_data = n_data; m_chan = n_chan;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1;
        step();
        n_vec++; if (act_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", act_rdy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_vec++; if (out_chan !== 2'd0) begin n_err++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
    endtask

    task automatic test_fixed();
        rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = 32'h0;
        in_data[2*8 +: 8] = 8'hA5;
        step();
        n_vec++; if (act_rdy !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready: got %b want 0100", act_rdy); end
        n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL fixed_out_data: got %h want a5", out_data); end
        n_vec++; if (out_chan !== 2'd2) begin n_err++; $display("FAIL fixed_out_chan: got %0d want 2", out_chan); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fixed_out_valid: got %b want 1", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 4'b1111;
        in_data = {8'h44, 8'h3C, 8'h22, 8'h11};
        for (int c = 0; c < 5; c++) begin
            step();
            n_vec++; if (act_rdy !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, act_rdy); end
            n_vec++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %h/%b want a5/1", c, out_data, out_valid);
            end
        end
        out_ready = 1'b1;
        step();
        n_vec++; if (act_rdy !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready: got %b want 0100", act_rdy); end
        n_vec++; if (out_data !== 8'h3C || out_chan !== 2'd2 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_release_out: got %h/%0d/%b want 3c/2/1", out_data, out_chan, out_valid);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++; if (act_rdy !== (4'b0001 << (i % 4))) begin
                n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, act_rdy, 4'b0001 << (i % 4));
            end
            n_vec++; if (int'(out_chan) !== (i % 4) || out_valid !== 1'b1 || out_data !== 8'(8'h10 + i % 4)) begin
                n_err++; $display("FAIL rr_seq[%0d]: got chan %0d valid %b data %h want chan %0d valid 1", i, out_chan, out_valid, out_data, i % 4);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [3:0] vpat [6];
        int         want [6];
        vpat = '{4'b0010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010};
        want = '{1, 3, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            in_valid = vpat[i];
            step();
            n_vec++; if (int'(out_chan) !== want[i] || out_valid !== 1'b1) begin
                n_err++; $display("FAIL rr_sparse[%0d]: got chan %0d valid %b want chan %0d valid 1", i, out_chan, out_valid, want[i]);
            end
        end
    endtask

    task automatic test_fixed_nogrant();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++; if (act_rdy !== 4'b0000) begin n_err++; $display("FAIL nogrant_ready[%0d]: got %b want 0000", c, act_rdy); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nogrant_drain[%0d]: got %b want 0", c, out_valid); end
        end
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++; if (act_rdy3 !== 3'b000 || out_valid3 !== 1'b0) begin
                n_err++; $display("FAIL ch3_sel3[%0d]: got ready %b valid %b want 000/0", c, act_rdy3, out_valid3);
            end
        end
        sel3 = 2'd2;
        step();
        n_vec++; if (act_rdy3 !== 3'b100 || out_valid3 !== 1'b1 || out_chan3 !== 2'd2 || out_data3 !== 8'h5A) begin
            n_err++; $display("FAIL ch3_sel2: got ready %b valid %b chan %0d data %h want 100/1/2/5a", act_rdy3, out_valid3, out_chan3, out_data3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        in_data = {8'h04, 8'h03, 8'h02, 8'hE7};
        step();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hE7) begin
            n_err++; $display("FAIL rmid_load: got %b/%h want 1/e7", out_valid, out_data);
        end
        out_ready = 1'b0; rst = 1'b1; in_valid = 4'b1111; mode = 1'b1;
        step();
        n_vec++; if (act_rdy !== 4'b0000) begin n_err++; $display("FAIL rmid_ready: got %b want 0000", act_rdy); end
        n_vec++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            n_err++; $display("FAIL rmid_clear: got %b/%h/%0d want 0/00/0", out_valid, out_data, out_chan);
        end
        rst = 1'b0; out_ready = 1'b1;
        step();
        n_vec++; if (out_chan !== 2'd0 || out_valid !== 1'b1 || out_data !== 8'hE7) begin
            n_err++; $display("FAIL rmid_first_rr: got chan %0d valid %b data %h want 0/1/e7", out_chan, out_valid, out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            n_vec++; if (act_rdy !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, act_rdy, exp_rdy);
            end
            n_vec++; if (out_valid !== m_valid || out_data !== m_data || int'(out_chan) !== m_chan) begin
                n_err++; $display("FAIL rand_out[%0d]: got %b/%h/%0d want %b/%h/%0d", c, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_data = 32'h0; in_valid = 4'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_data3 = 24'h5A_0000; in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd3;
        test_reset();
        test_fixed();
        test_backpressure();
        test_round_robin();
        test_rr_sparse();
        test_fixed_nogrant();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sel_mux_rr.md
# sel_mux_rr

Parametrised, registered N-channel selector with valid/ready handshaking on every input and on the output. It is the successor to the datapath's fixed 4:1 8-bit operand multiplexer. It supports two modes: a fixed select, where software or control picks the channel, and a fair round-robin mode, where the block arbitrates among requesting channels. It sits between operand/register sources and the ALU or bus staging register and adds exactly one cycle of latency.

## Interface
- WIDTH, 8, data width per channel
- CHANNELS, 4, number of input channels (≥2; need not be a power of 2)
- SEL_W, $clog2(CHANNELS), width of sel and out_chan

Ports:
- clk  in  1  rising-edge clock; the single clock domain
- rst  in  1  synchronous, active-high reset
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel request
- in_ready  out  CHANNELS  per-channel accept; at most one bit high
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel selected in fixed mode
- out_data  out  WIDTH  registered selected data
- out_chan  out  SEL_W  index of the channel that produced out_data
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  downstream accept

## Operation
- Single output register. `space = !out_valid || out_ready`.
- Grant `g` is combinational from in_valid, mode, sel and the round-robin pointer `ptr`.
  - Fixed mode: a grant exists iff `sel < CHANNELS` and `in_valid[sel]`, and then `g = sel`.
  - Round-robin mode: `g` is the first index with in_valid set, searching `ptr+1, ptr+2, …` modulo CHANNELS. `ptr` itself is checked last.
  - No requesting channel: no grant.
- `load = space && grant_exists`. in_ready[g] = load; every other in_ready bit is 0. in_ready is never asserted for a channel whose in_valid is low.
- On load at a clock edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In round-robin mode only, ptr <= g. In fixed mode, ptr holds.
- If out_valid && out_ready and there is no load: out_valid <= 0. out_data and out_chan hold their last values.
- If out_valid && !out_ready: all output registers hold, and in_ready is all zero.
- Transfer rules:
  - An input transfer occurs when in_valid[k] && in_ready[k].
  - An output transfer occurs when out_valid && out_ready.
  - Both can happen in the same cycle, giving back-to-back throughput of 1 word/cycle.
- A mode or sel change takes effect in the same cycle's grant decision, with no pipeline delay. Switching fixed→round-robin resumes the search from the retained ptr.
- sel ≥ CHANNELS in fixed mode: no grant, and no error flag.
- Round-robin fairness: with all channels continuously valid and out_ready high, grants are 0,1,…,CHANNELS-1,0,… with no channel skipped.

## Timing
- Reset (rst high at a clk edge):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - ptr = CHANNELS-1, so the first round-robin grant favours channel 0.
  - in_ready = 0 during the reset cycle.
- Reset mid-operation discards any held word. No input transfer is accepted in the reset cycle.
- Latency: data accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. There is no combinational path from in_data to any output.
- Upstream drivers must not make in_valid depend on in_ready.

## Test plan
1. Reset, then fixed mode, sel=2, in_valid=4'b0100, in_data channel 2 = 8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2, out_valid=1.
2. Backpressure: out_valid=1, out_ready=0, all in_valid=1 → in_ready=0 and out_data stable for 5 cycles. Raise out_ready → a new word loads the same cycle the old word is consumed.
3. Round-robin, all in_valid=1, out_ready=1 for 8 cycles after reset → out_chan sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
4. Round-robin, in_valid=4'b1010 after a grant to channel 1 → next grant 3, then 1. With only channel 1 valid → repeated grants to 1.
5. Fixed mode with sel=1 and in_valid=4'b1101 → no grant, in_ready=0; out_valid drains to 0 after one out_ready cycle. With CHANNELS=3 and sel=3 → never grants.
6. Assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, out_chan=0. The first round-robin grant after reset goes to channel 0.
